viewport_unproject: RTL and testbench

- Inverse of the NDC-to-renormalized-screen projection stage.
- On a start command it latches one depth plane z and raster-scans every viewport pixel in row-major order.
- For each pixel it maps the centre to renormalized coordinates in (-1,1), multiplies by z and emits the NDC point (x·z, y·z, z).
- Feeds ray/plane generation for the hologram back-projection path through a valid/ready stream.

---
 rtl/viewport_unproject_pkg.sv | 29 ++
 rtl/viewport_unproject_if.sv | 28 ++
 rtl/viewport_unproject_pixel_scan_counter.sv | 39 +++
 rtl/viewport_unproject.sv | 129 ++++++++++++
 tb/tb_viewport_unproject.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/viewport_unproject_pkg.sv
// Shared types and fixed-point helpers for the viewport unprojection stage.
// UNPROJECT_ROUND_EN selects round-half-up instead of floor in mul_shift.
package unproject_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_t;

    function automatic int dot_prod_width(input int c_width, input int n_width, input int frac_bits);
        return c_width + n_width - frac_bits + 2;
    endfunction

    // Full-width product followed by an arithmetic (flooring) shift.
    function automatic logic signed [63:0] mul_shift(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        frac
    );
        logic signed [63:0] p;
        p = a * b;
`ifdef UNPROJECT_ROUND_EN
        p = p + (64'sd1 <<< (frac - 1));
`endif
        return p >>> frac;
    endfunction

endpackage

// File: rtl/viewport_unproject_if.sv
// Start/stream interface for viewport_unproject: command side plus the
// valid/ready point stream and status flags.
interface viewport_unproject_if #(
    parameter int DPW = 22,
    parameter int HW  = 9,
    parameter int VW  = 8
);
    logic                         start_in;
    logic signed [DPW-1:0]        z_in;
    logic                         ready_in;
    logic                         valid_out;
    logic signed [2:0][DPW-1:0]   ndc_out;
    logic        [HW-1:0]         hcount_out;
    logic        [VW-1:0]         vcount_out;
    logic                         last_out;
    logic                         busy_out;
    logic                         done_out;

    modport slave (
        input  start_in, z_in, ready_in,
        output valid_out, ndc_out, hcount_out, vcount_out, last_out, busy_out, done_out
    );

    modport master (
        output start_in, z_in, ready_in,
        input  valid_out, ndc_out, hcount_out, vcount_out, last_out, busy_out, done_out
    );
endinterface

// File: rtl/viewport_unproject_pixel_scan_counter.sv
// Row-major pixel counter: h wraps at W-1 and carries into v; last flags (W-1,H-1).
module pixel_scan_counter #(
    parameter int W  = 320,
    parameter int H  = 180,
    parameter int HW = $clog2(W),
    parameter int VW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          last
);
    localparam logic [HW-1:0] H_MAX = HW'(W - 1);
    localparam logic [VW-1:0] V_MAX = VW'(H - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (clear) begin
            h <= '0;
            v <= '0;
        end else if (enable) begin
            if (h == H_MAX) begin
                h <= '0;
                v <= (v == V_MAX) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    always_comb begin
        last = (h == H_MAX) && (v == V_MAX);
    end
endmodule

// File: rtl/viewport_unproject.sv
// Raster-scans the viewport at one latched depth and emits NDC points (x*z, y*z, z).
// Build option: UNPROJECT_ROUND_EN (round-half-up on the z multiply).
module viewport_unproject
    import unproject_pkg::*;
#(
    parameter int FRAC_BITS  = 14,
    parameter int N_WIDTH    = 16,
    parameter int C_WIDTH    = 18,
    parameter int VIEWPORT_W = 320,
    parameter int VIEWPORT_H = 180
) (
    input logic              clk_in,
    input logic              rst_in,
    viewport_unproject_if.slave bus
);
    localparam int DPW   = dot_prod_width(C_WIDTH, N_WIDTH, FRAC_BITS);
    localparam int INV_W = (1 << FRAC_BITS) / VIEWPORT_W;
    localparam int INV_H = (1 << FRAC_BITS) / VIEWPORT_H;
    localparam int RW    = FRAC_BITS + 2;
    localparam int HW    = $clog2(VIEWPORT_W);
    localparam int VW    = $clog2(VIEWPORT_H);

    scan_state_t           state;
    logic signed [DPW-1:0] z_lat;
    logic                  en;
    logic                  issue;
    logic                  cnt_clear;
    logic [HW-1:0]         cnt_h;
    logic [VW-1:0]         cnt_v;
    logic                  cnt_last;

    logic                  s1_valid, s1_last;
    logic [HW-1:0]         s1_h;
    logic [VW-1:0]         s1_v;
    logic                  s2_valid, s2_last;
    logic [HW-1:0]         s2_h;
    logic [VW-1:0]         s2_v;
    logic signed [RW-1:0]  s2_xr, s2_yr;

    always_comb begin
        en        = !(bus.valid_out && !bus.ready_in);
        issue     = (state == SCAN) && en;
        cnt_clear = (state == IDLE) && bus.start_in;
    end

    pixel_scan_counter #(
        .W  (VIEWPORT_W),
        .H  (VIEWPORT_H),
        .HW (HW),
        .VW (VW)
    ) u_scan (
        .clk    (clk_in),
        .rst    (rst_in),
        .clear  (cnt_clear),
        .enable (issue),
        .h      (cnt_h),
        .v      (cnt_v),
        .last   (cnt_last)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            z_lat          <= '0;
            s1_valid       <= 1'b0;
            s1_last        <= 1'b0;
            s1_h           <= '0;
            s1_v           <= '0;
            s2_valid       <= 1'b0;
            s2_last        <= 1'b0;
            s2_h           <= '0;
            s2_v           <= '0;
            s2_xr          <= '0;
            s2_yr          <= '0;
            bus.valid_out  <= 1'b0;
            bus.ndc_out    <= '0;
            bus.hcount_out <= '0;
            bus.vcount_out <= '0;
            bus.last_out   <= 1'b0;
            bus.busy_out   <= 1'b0;
            bus.done_out   <= 1'b0;
        end else begin
            bus.done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_in) begin
                        z_lat        <= bus.z_in;
                        state        <= SCAN;
                        bus.busy_out <= 1'b1;
                    end
                end
                SCAN: begin
                    if (issue && cnt_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.valid_out && bus.ready_in && bus.last_out) begin
                        state        <= IDLE;
                        bus.busy_out <= 1'b0;
                        bus.done_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Single enable freezes all three stages together under backpressure.
            if (en) begin
                s1_valid <= issue;
                s1_last  <= issue && cnt_last;
                s1_h     <= cnt_h;
                s1_v     <= cnt_v;

                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_h     <= s1_h;
                s2_v     <= s1_v;
                s2_xr    <= RW'((2 * int'(s1_h) + 1 - VIEWPORT_W) * INV_W);
                s2_yr    <= RW'((VIEWPORT_H - (2 * int'(s1_v) + 1)) * INV_H);

                bus.valid_out  <= s2_valid;
                bus.last_out   <= s2_last;
                bus.hcount_out <= s2_h;
                bus.vcount_out <= s2_v;
                bus.ndc_out[0] <= DPW'(mul_shift(64'(s2_xr), 64'(z_lat), FRAC_BITS));
                bus.ndc_out[1] <= DPW'(mul_shift(64'(s2_yr), 64'(z_lat), FRAC_BITS));
                bus.ndc_out[2] <= z_lat;
            end
        end
    end
endmodule

// File: tb/tb_viewport_unproject.sv
// Directed self-checking bench for viewport_unproject on a 4x2 viewport.
module tb_viewport_unproject;
    localparam int DPW = 22;
    localparam int W   = 4;
    localparam int H   = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    viewport_unproject_if #(.DPW(DPW), .HW(2), .VW(1)) bus ();

    viewport_unproject #(
        .FRAC_BITS  (14),
        .N_WIDTH    (16),
        .C_WIDTH    (18),
        .VIEWPORT_W (W),
        .VIEWPORT_H (H)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (bus.valid_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (bus.valid_out !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL %s: timeout waiting for valid_out after %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (bus.done_out !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, 64'(bus.done_out), 64'sd1);
    endtask

    // Expected beat i for an exact power-of-two depth; checks then accepts it.
    task automatic take_beat(input string tag, input int i, input int z, input int budget);
        int h, v;
        logic signed [63:0] ex, ey;
        h  = i % W;
        v  = i / W;
        ex = (64'(((2 * h + 1) - W) * 4096) * 64'(z)) >>> 14;
        ey = (64'((H - (2 * v + 1)) * 8192) * 64'(z)) >>> 14;
        wait_valid(tag, budget);
        check({tag, "_valid"}, 64'(bus.valid_out), 64'sd1);
        check({tag, "_h"}, 64'(bus.hcount_out), 64'(h));
        check({tag, "_v"}, 64'(bus.vcount_out), 64'(v));
        check({tag, "_x"}, $signed(bus.ndc_out[0]), ex);
        check({tag, "_y"}, $signed(bus.ndc_out[1]), ey);
        check({tag, "_z"}, $signed(bus.ndc_out[2]), 64'(z));
        check({tag, "_last"}, 64'(bus.last_out), (i == W * H - 1) ? 64'sd1 : 64'sd0);
        step();
    endtask

    initial begin
        logic signed [63:0] hx, hy, hz;
        int                 hh;

        rst          = 1'b1;
        bus.start_in = 1'b0;
        bus.z_in     = '0;
        bus.ready_in = 1'b1;
        step();
        step();
        check("rst_valid", 64'(bus.valid_out), 64'sd0);
        check("rst_ndc", 64'(bus.ndc_out), 64'sd0);
        check("rst_h", 64'(bus.hcount_out), 64'sd0);
        check("rst_v", 64'(bus.vcount_out), 64'sd0);
        check("rst_last", 64'(bus.last_out), 64'sd0);
        check("rst_busy", 64'(bus.busy_out), 64'sd0);
        check("rst_done", 64'(bus.done_out), 64'sd0);
        rst = 1'b0;
        step();

        // Basic frame with exact latency and no bubbles.
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd16384;
        step();
        bus.start_in = 1'b0;
        bus.z_in     = '0;
        check("basic_busy", 64'(bus.busy_out), 64'sd1);
        check("basic_lat0", 64'(bus.valid_out), 64'sd0);
        step();
        check("basic_lat1", 64'(bus.valid_out), 64'sd0);
        step();
        check("basic_lat2", 64'(bus.valid_out), 64'sd0);
        step();
        for (int i = 0; i < W * H; i++) take_beat("basic", i, 16384, 0);
        check("basic_done", 64'(bus.done_out), 64'sd1);
        check("basic_idle", 64'(bus.busy_out), 64'sd0);
        check("basic_novalid", 64'(bus.valid_out), 64'sd0);
        step();
        check("basic_done_pulse", 64'(bus.done_out), 64'sd0);
        step();

        // Backpressure at beat 3 for five cycles.
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd16384;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < 3; i++) take_beat("bp", i, 16384, 10);
        wait_valid("bp_hold", 10);
        bus.ready_in = 1'b0;
        hx = $signed(bus.ndc_out[0]);
        hy = $signed(bus.ndc_out[1]);
        hz = $signed(bus.ndc_out[2]);
        hh = int'(bus.hcount_out);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", 64'(bus.valid_out), 64'sd1);
            check("bp_hold_h", 64'(bus.hcount_out), 64'(hh));
            check("bp_hold_x", $signed(bus.ndc_out[0]), hx);
            check("bp_hold_y", $signed(bus.ndc_out[1]), hy);
            check("bp_hold_z", $signed(bus.ndc_out[2]), hz);
        end
        bus.ready_in = 1'b1;
        for (int i = 3; i < W * H; i++) take_beat("bp", i, 16384, 0);
        check("bp_done", 64'(bus.done_out), 64'sd1);
        step();
        step();

        // Rounding at pixel (0,0) with z=3.
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd3;
        step();
        bus.start_in = 1'b0;
        wait_valid("round", 10);
`ifdef UNPROJECT_ROUND_EN
        check("round_x", $signed(bus.ndc_out[0]), -64'sd2);
        check("round_y", $signed(bus.ndc_out[1]), 64'sd2);
`else
        check("round_x", $signed(bus.ndc_out[0]), -64'sd3);
        check("round_y", $signed(bus.ndc_out[1]), 64'sd1);
`endif
        check("round_z", $signed(bus.ndc_out[2]), 64'sd3);
        wait_done("round", 20);
        step();

        // Start pulsed mid-scan must be ignored.
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd16384;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < 2; i++) take_beat("ign", i, 16384, 10);
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd999;
        step();
        bus.start_in = 1'b0;
        for (int i = 3; i < W * H; i++) take_beat("ign", i, 16384, 0);
        check("ign_done", 64'(bus.done_out), 64'sd1);
        for (int k = 0; k < 5; k++) step();
        check("ign_norestart_busy", 64'(bus.busy_out), 64'sd0);
        check("ign_norestart_valid", 64'(bus.valid_out), 64'sd0);

        // Async reset at beat 4, then a fresh full frame.
        bus.start_in = 1'b1;
        bus.z_in     = 22'sd16384;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < 4; i++) take_beat("rst", i, 16384, 10);
        wait_valid("rst_b4", 10);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.valid_out), 64'sd0);
        check("arst_busy", 64'(bus.busy_out), 64'sd0);
        step();
        rst = 1'b0;
        step();
        check("arst_quiet", 64'(bus.valid_out), 64'sd0);
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        for (int i = 0; i < W * H; i++) take_beat("post_rst", i, 16384, 10);
        check("post_rst_done", 64'(bus.done_out), 64'sd1);

        // Back-to-back: start in the done cycle with negated depth.
        bus.start_in = 1'b1;
        bus.z_in     = -22'sd16384;
        step();
        bus.start_in = 1'b0;
        bus.z_in     = '0;
        step();
        step();
        step();
        for (int i = 0; i < W * H; i++) take_beat("b2b", i, -16384, 0);
        check("b2b_done", 64'(bus.done_out), 64'sd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "global timeout");
    end
endmodule
